// File: rtl/pwm_gen_multi_if.sv
// pwm_gen_multi_if: config/status bundle between the register
// file (master) and the multi-channel PWM generator (slave).
interface pwm_gen_multi_if #(
  parameter int CH    = 4,
  parameter int W     = 16,
  parameter int PSC_W = 8
);
  logic             pwm_en;
  logic [PSC_W-1:0] prescale;
  logic [W-1:0]     period_in;
  logic [3*CH-1:0]  mode_in;
  logic [W*CH-1:0]  compare1_in;
  logic [W*CH-1:0]  compare2_in;
  logic             cfg_wr;
  logic             cfg_pending;
  logic [W-1:0]     count_val;
  logic             period_evt;
  logic [CH-1:0]    pwm_out;

  modport master (
    output pwm_en, prescale, period_in, mode_in,
    output compare1_in, compare2_in, cfg_wr,
    input  cfg_pending, count_val, period_evt, pwm_out
  );

  modport slave (
    input  pwm_en, prescale, period_in, mode_in,
    input  compare1_in, compare2_in, cfg_wr,
    output cfg_pending, count_val, period_evt, pwm_out
  );
endinterface

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: prescaled period counter driving CH PWM channels
// with left/right/window/toggle modes and double-buffered config.
module pwm_gen_multi #(
  parameter int CH    = 4,
  parameter int W     = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_gen_multi_if.slave   bus
);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic [W-1:0]     per_q, per_d, per_p_q, per_p_d;
  logic [3*CH-1:0]  mode_q, mode_d, mode_p_q, mode_p_d;
  logic [W*CH-1:0]  c1_q, c1_d, c1_p_q, c1_p_d;
  logic [W*CH-1:0]  c2_q, c2_d, c2_p_q, c2_p_d;
  logic             pend_q, pend_d;
  logic [CH-1:0]    tog_q, tog_d;
  logic [CH-1:0]    out_q, out_d;
  logic             tick, wrap, apply;

  // Tick also fires when prescale drops below the running count.
  always_comb begin
    tick  = bus.pwm_en && (psc_q >= bus.prescale);
    wrap  = tick && (cnt_q == per_q);
    apply = wrap || !bus.pwm_en;
  end

  // Prescaler and period counter, both parked at 0 while disabled.
  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    evt_d = wrap;
    if (!bus.pwm_en) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      psc_d = '0;
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

  // Double buffer: a write landing on an apply goes straight to active.
  always_comb begin
    per_p_d  = per_p_q;
    mode_p_d = mode_p_q;
    c1_p_d   = c1_p_q;
    c2_p_d   = c2_p_q;
    pend_d   = pend_q;
    per_d    = per_q;
    mode_d   = mode_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    if (bus.cfg_wr) begin
      per_p_d  = bus.period_in;
      mode_p_d = bus.mode_in;
      c1_p_d   = bus.compare1_in;
      c2_p_d   = bus.compare2_in;
    end
    if (apply) begin
      per_d  = per_p_d;
      mode_d = mode_p_d;
      c1_d   = c1_p_d;
      c2_d   = c2_p_d;
      pend_d = 1'b0;
    end else if (bus.cfg_wr) begin
      pend_d = 1'b1;
    end
  end

  // Per-channel compare logic; outputs freeze while disabled.
  always_comb begin : ch_eval
    logic [1:0]   m;
    logic         inv;
    logic         raw;
    logic [W-1:0] a;
    logic [W-1:0] b;
    tog_d = tog_q;
    out_d = out_q;
    m     = '0;
    inv   = 1'b0;
    raw   = 1'b0;
    a     = '0;
    b     = '0;
    for (int c = 0; c < CH; c++) begin
      m   = mode_q[3*c +: 2];
      inv = mode_q[3*c+2];
      a   = c1_q[W*c +: W];
      b   = c2_q[W*c +: W];
      unique case (m)
        2'b00: raw = (cnt_q < a);
        2'b01: raw = (cnt_q >= a);
        2'b10: raw = (cnt_q >= a) && (cnt_q < b);
        2'b11: raw = tog_q[c];
      endcase
      if (apply && (mode_p_d[3*c +: 2] != m))
        tog_d[c] = 1'b0;
      else if (tick && (m == 2'b11) && (cnt_q == a))
        tog_d[c] = ~tog_q[c];
      if (bus.pwm_en)
        out_d[c] = raw ^ inv;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q    <= '0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      per_q    <= '0;
      mode_q   <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      per_p_q  <= '0;
      mode_p_q <= '0;
      c1_p_q   <= '0;
      c2_p_q   <= '0;
      pend_q   <= 1'b0;
      tog_q    <= '0;
      out_q    <= '0;
    end else begin
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      per_q    <= per_d;
      mode_q   <= mode_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      per_p_q  <= per_p_d;
      mode_p_q <= mode_p_d;
      c1_p_q   <= c1_p_d;
      c2_p_q   <= c2_p_d;
      pend_q   <= pend_d;
      tog_q    <= tog_d;
      out_q    <= out_d;
    end
  end

  assign bus.cfg_pending = pend_q;
  assign bus.count_val   = cnt_q;
  assign bus.period_evt  = evt_q;
  assign bus.pwm_out     = out_q;

endmodule
